// File: rtl/ft_phy_pkg.sv
// Shared types for the FTDI synchronous-FIFO PHY: engine states, burst direction
// and the RX FIFO slack the almost-full flag is built around.
package ft_phy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_TURN,
        RX_BURST,
        TX_BURST,
        GAP
    } state_t;

    typedef enum logic {
        DIR_RX,
        DIR_TX
    } dir_t;

    // rx_afull rises with this many free slots left; at most SLACK-1 words land after it.
    localparam int RX_AFULL_SLACK = 3;

endpackage

// File: rtl/ft_rr_arb.sv
// Two-requester round-robin arbiter; remembers which direction was served last
// so that contending RX and TX requests alternate.
module ft_rr_arb
    import ft_phy_pkg::*;
(
    input  logic ftdi_clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_rx_req,
    input  logic i_tx_req,
    output logic o_grant_rx,
    output logic o_grant_tx
);

    dir_t r_last_served;

    always_comb begin
        o_grant_rx = i_en && i_rx_req && (!i_tx_req || (r_last_served == DIR_TX));
        o_grant_tx = i_en && i_tx_req && !o_grant_rx;
    end

    // Reset to TX so the first contended grant after reset goes to RX.
    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            r_last_served <= DIR_TX;
        end else if (o_grant_rx) begin
            r_last_served <= DIR_RX;
        end else if (o_grant_tx) begin
            r_last_served <= DIR_TX;
        end
    end

endmodule

// File: rtl/ft_sync_phy_arb.sv
// FTDI synchronous-FIFO PHY engine: arbitrates RX/TX bursts on the shared pad,
// bounds burst length, inserts turnaround gaps and issues SIWU flushes.
module ft_sync_phy_arb
    import ft_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 64,
    parameter int CNT_W      = 7
) (
    input  logic                  ftdi_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ftdi_data_i,
    output logic [DATA_WIDTH-1:0] ftdi_data_o,
    output logic                  ftdi_data_t,
    input  logic                  ftdi_rxf_n,
    input  logic                  ftdi_txe_n,
    output logic                  ftdi_rd_n,
    output logic                  ftdi_oe_n,
    output logic                  ftdi_wr_n,
    output logic                  ftdi_siwu_n,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_sof,
    output logic                  rx_wr,
    input  logic                  rx_afull,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_empty,
    output logic                  tx_rd,
    input  logic                  tx_flush,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_oe_n;
    logic                  r_rd_n;
    logic                  r_siwu_n;
    logic                  r_data_t;
    logic                  r_rx_wr;
    logic                  r_rx_sof;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_flush_pend;
    logic                  r_new_txn;

    logic w_rx_req;
    logic w_tx_req;
    logic w_tx_rd;
    logic w_capture;
    logic w_flush_go;
    logic w_grant_rx;
    logic w_grant_tx;

    assign w_rx_req   = !ftdi_rxf_n && !rx_afull;
    assign w_tx_req   = !ftdi_txe_n && !tx_empty;
    assign w_tx_rd    = (r_state == TX_BURST) && w_tx_req && (r_cnt < CNT_MAX);
    assign w_capture  = (r_state == RX_BURST) && !r_rd_n && !ftdi_rxf_n;
    assign w_flush_go = (r_state == IDLE) && tx_empty && r_flush_pend && !w_rx_req && !w_tx_req;

    ft_rr_arb u_arb (
        .ftdi_clk   (ftdi_clk),
        .rst        (rst),
        .i_en       (r_state == IDLE),
        .i_rx_req   (w_rx_req),
        .i_tx_req   (w_tx_req),
        .o_grant_rx (w_grant_rx),
        .o_grant_tx (w_grant_tx)
    );

    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_oe_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_siwu_n     <= 1'b1;
            r_data_t     <= 1'b0;
            r_rx_wr      <= 1'b0;
            r_rx_sof     <= 1'b0;
            r_rx_data    <= '0;
            r_flush_pend <= 1'b0;
            r_new_txn    <= 1'b1;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments in the same block,
            // which is what makes rx_wr/rx_sof/siwu_n single-cycle pulses.
            r_rx_wr      <= 1'b0;
            r_rx_sof     <= 1'b0;
            r_siwu_n     <= 1'b1;
            r_flush_pend <= r_flush_pend | tx_flush;
            if (ftdi_rxf_n) begin
                r_new_txn <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_flush_go) begin
                        r_siwu_n     <= 1'b0;
                        r_flush_pend <= tx_flush;
                    end
                    if (w_grant_rx) begin
                        r_oe_n  <= 1'b0;
                        r_state <= RX_TURN;
                    end else if (w_grant_tx) begin
                        r_data_t <= 1'b1;
                        r_state  <= TX_BURST;
                    end
                end
                RX_TURN: begin
                    r_rd_n  <= 1'b0;
                    r_state <= RX_BURST;
                end
                RX_BURST: begin
                    if (w_capture) begin
                        r_rx_data <= ftdi_data_i;
                        r_rx_wr   <= 1'b1;
                        r_rx_sof  <= r_new_txn;
                        r_new_txn <= 1'b0;
                        r_cnt     <= r_cnt + 1'b1;
                    end
                    if (ftdi_rxf_n || rx_afull || (w_capture && (r_cnt == CNT_LAST))) begin
                        r_rd_n  <= 1'b1;
                        r_state <= GAP;
                    end
                end
                TX_BURST: begin
                    if (w_tx_rd) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (!w_tx_req || (w_tx_rd && (r_cnt == CNT_LAST))) begin
                        r_data_t <= 1'b0;
                        r_state  <= GAP;
                    end
                end
                GAP: begin
                    // oe_n lags rd_n by a cycle so the FTDI releases the bus before any TX.
                    r_oe_n  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ftdi_oe_n   = r_oe_n;
    assign ftdi_rd_n   = r_rd_n;
    assign ftdi_siwu_n = r_siwu_n;
    assign ftdi_data_t = r_data_t;
    assign ftdi_wr_n   = ~w_tx_rd;
    assign ftdi_data_o = (r_state == TX_BURST) ? tx_data : '0;
    assign tx_rd       = w_tx_rd;
    assign rx_wr       = r_rx_wr;
    assign rx_sof      = r_rx_sof;
    assign rx_data     = r_rx_data;
    assign busy        = (r_state != IDLE);

endmodule
